// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - simulation control: core reset sequencing, halt/exit-code collection, watchdog, verdict
module sim_ctrl #(
  parameter int NUM_HARTS      = 1,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int DRAIN_CYCLES   = 4,
  parameter int CNT_W          = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_HARTS-1:0]   ebreak_end,
  input  logic [NUM_HARTS-1:0]   commit,
  input  logic [32*NUM_HARTS-1:0] exit_code,
  output logic                   dut_rst_n,
  output logic                   sim_done,
  output logic                   sim_pass,
  output logic                   sim_timeout,
  output logic [NUM_HARTS-1:0]   halt_mask,
  output logic [NUM_HARTS-1:0]   fail_mask,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instret_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DR_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LIM  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [DR_W-1:0] DR_LIM  = DR_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {ST_RST, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t               state, state_nxt;
  logic [RC_W-1:0]      rst_cnt, rst_cnt_nxt;
  logic [WD_W-1:0]      wd, wd_nxt;
  logic [DR_W-1:0]      drain_cnt, drain_cnt_nxt;
  logic                 dut_rst_n_nxt, done_nxt, pass_nxt, timeout_nxt;
  logic [NUM_HARTS-1:0] halt_nxt, fail_nxt, new_halt, halt_all, code_nz;
  logic [CNT_W-1:0]     cycle_nxt, instret_nxt, pop;

  always_comb begin
    state_nxt     = state;
    rst_cnt_nxt   = rst_cnt;
    wd_nxt        = wd;
    drain_cnt_nxt = drain_cnt;
    dut_rst_n_nxt = dut_rst_n;
    done_nxt      = sim_done;
    pass_nxt      = sim_pass;
    timeout_nxt   = sim_timeout;
    halt_nxt      = halt_mask;
    fail_nxt      = fail_mask;
    cycle_nxt     = cycle_cnt;
    instret_nxt   = instret_cnt;
    pop           = '0;
    code_nz       = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      code_nz[i] = |exit_code[32*i +: 32];
      pop        = pop + CNT_W'(commit[i]);
    end
    // Only the first rise of a level-sensitive halt is acted on
    new_halt = ebreak_end & ~halt_mask;
    halt_all = halt_mask | new_halt;

    case (state)
      ST_RST: begin
        if (rst_cnt == RC_LAST) begin
          state_nxt     = ST_RUN;
          dut_rst_n_nxt = 1'b1;
        end else begin
          rst_cnt_nxt = rst_cnt + RC_W'(1);
        end
      end
      ST_RUN: begin
        cycle_nxt   = cycle_cnt + CNT_W'(1);
        instret_nxt = instret_cnt + pop;
        halt_nxt    = halt_all;
        fail_nxt    = fail_mask | (new_halt & code_nz);
        wd_nxt      = ((|commit) || (|new_halt)) ? '0 : wd + WD_W'(1);
        // The final halt takes priority over a coincident watchdog expiry
        if (&halt_all) begin
          if (DRAIN_CYCLES == 0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            pass_nxt  = ~|fail_nxt;
          end else begin
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = '0;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (wd_nxt == WD_LIM)) begin
          state_nxt   = ST_DONE;
          done_nxt    = 1'b1;
          timeout_nxt = 1'b1;
          pass_nxt    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DR_LIM) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          pass_nxt  = ~|fail_mask;
        end else begin
          drain_cnt_nxt = drain_cnt + DR_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RST;
      rst_cnt     <= '0;
      wd          <= '0;
      drain_cnt   <= '0;
      dut_rst_n   <= 1'b0;
      sim_done    <= 1'b0;
      sim_pass    <= 1'b0;
      sim_timeout <= 1'b0;
      halt_mask   <= '0;
      fail_mask   <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      wd          <= wd_nxt;
      drain_cnt   <= drain_cnt_nxt;
      dut_rst_n   <= dut_rst_n_nxt;
      sim_done    <= done_nxt;
      sim_pass    <= pass_nxt;
      sim_timeout <= timeout_nxt;
      halt_mask   <= halt_nxt;
      fail_mask   <= fail_nxt;
      cycle_cnt   <= cycle_nxt;
      instret_cnt <= instret_nxt;
    end
  end

endmodule

// File: tb/tb_sim_ctrl.sv
// tb/tb_sim_ctrl.sv - scoreboard bench for sim_ctrl (single-hart and four-hart instances)
module tb_sim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  logic        rst1 = 1'b0, eb1 = 1'b0, cm1 = 1'b0;
  logic [31:0] code1 = '0;
  logic        d1_rstn, d1_done, d1_pass, d1_tmo;
  logic [0:0]  d1_hm, d1_fm;
  logic [63:0] d1_cyc, d1_inst;

  logic         rst4 = 1'b0;
  logic [3:0]   eb4 = '0, cm4 = '0;
  logic [127:0] code4 = '0;
  logic         d4_rstn, d4_done, d4_pass, d4_tmo;
  logic [3:0]   d4_hm, d4_fm;
  logic [63:0]  d4_cyc, d4_inst;

  sim_ctrl #(.NUM_HARTS(1), .RST_CYCLES(16), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(4), .CNT_W(64)) u1 (
    .clk(clk), .rst_n(rst1), .ebreak_end(eb1), .commit(cm1), .exit_code(code1),
    .dut_rst_n(d1_rstn), .sim_done(d1_done), .sim_pass(d1_pass), .sim_timeout(d1_tmo),
    .halt_mask(d1_hm), .fail_mask(d1_fm), .cycle_cnt(d1_cyc), .instret_cnt(d1_inst));

  sim_ctrl #(.NUM_HARTS(4), .RST_CYCLES(16), .TIMEOUT_CYCLES(1000), .DRAIN_CYCLES(4), .CNT_W(64)) u4 (
    .clk(clk), .rst_n(rst4), .ebreak_end(eb4), .commit(cm4), .exit_code(code4),
    .dut_rst_n(d4_rstn), .sim_done(d4_done), .sim_pass(d4_pass), .sim_timeout(d4_tmo),
    .halt_mask(d4_hm), .fail_mask(d4_fm), .cycle_cnt(d4_cyc), .instret_cnt(d4_inst));

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [3:0]  hm;
    logic [3:0]  fm;
    logic [63:0] cyc;
    logic [63:0] inst;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  logic p1 = 1'b0, p4 = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every rising sim_done is matched against the oldest pending expectation
  always @(negedge clk) begin
    if (d1_done === 1'b1 && p1 !== 1'b1) begin
      if (q1.size() == 0) chk("u1_spurious_done", 64'(q1.size()), 64'd1);
      else begin
        e1 = q1.pop_front();
        chk("u1_done_edge", 64'(edge_n), 64'(e1.at));
        chk("u1_sim_pass", 64'(d1_pass), 64'(e1.pass));
        chk("u1_sim_timeout", 64'(d1_tmo), 64'(e1.tmo));
        chk("u1_halt_mask", 64'(d1_hm), 64'(e1.hm));
        chk("u1_fail_mask", 64'(d1_fm), 64'(e1.fm));
        chk("u1_cycle_cnt", d1_cyc, e1.cyc);
        chk("u1_instret_cnt", d1_inst, e1.inst);
      end
    end
    p1 = d1_done;
    if (d4_done === 1'b1 && p4 !== 1'b1) begin
      if (q4.size() == 0) chk("u4_spurious_done", 64'(q4.size()), 64'd1);
      else begin
        e4 = q4.pop_front();
        chk("u4_done_edge", 64'(edge_n), 64'(e4.at));
        chk("u4_sim_pass", 64'(d4_pass), 64'(e4.pass));
        chk("u4_sim_timeout", 64'(d4_tmo), 64'(e4.tmo));
        chk("u4_halt_mask", 64'(d4_hm), 64'(e4.hm));
        chk("u4_fail_mask", 64'(d4_fm), 64'(e4.fm));
        chk("u4_cycle_cnt", d4_cyc, e4.cyc);
        chk("u4_instret_cnt", d4_inst, e4.inst);
      end
    end
    p4 = d4_done;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start1();
    rst1 = 1'b0; eb1 = 1'b0; cm1 = 1'b0; code1 = '0;
    tick(); tick();
    chk("u1_rst_dut_rst_n", 64'(d1_rstn), 64'd0);
    chk("u1_rst_sim_done", 64'(d1_done), 64'd0);
    chk("u1_rst_sim_pass", 64'(d1_pass), 64'd0);
    chk("u1_rst_sim_timeout", 64'(d1_tmo), 64'd0);
    chk("u1_rst_halt_mask", 64'(d1_hm), 64'd0);
    chk("u1_rst_fail_mask", 64'(d1_fm), 64'd0);
    chk("u1_rst_cycle_cnt", d1_cyc, 64'd0);
    chk("u1_rst_instret_cnt", d1_inst, 64'd0);
    rst1 = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 15) chk("u1_dut_rst_n_edge15", 64'(d1_rstn), 64'd0);
    end
    chk("u1_dut_rst_n_edge16", 64'(d1_rstn), 64'd1);
    chk("u1_cycle_cnt_run_start", d1_cyc, 64'd0);
  endtask

  // halt_at=0 means no halt; lat is the sim_done edge counted from the last RST edge
  task automatic run1(input int halt_at, input logic [31:0] code, input int ncommit,
                      input logic pass, input logic tmo, input logic hm, input logic fm,
                      input int cyc, input int inst, input int lat);
    exp_t e;
    e.pass = pass; e.tmo = tmo; e.hm = {3'b000, hm}; e.fm = {3'b000, fm};
    e.cyc = 64'(cyc); e.inst = 64'(inst); e.at = edge_n + lat;
    q1.push_back(e);
    for (int n = 1; n <= 200 && q1.size() != 0; n++) begin
      cm1 = (n <= ncommit);
      if (n == halt_at) begin
        eb1 = 1'b1;
        code1 = code;
      end
      if (halt_at > 0 && n == halt_at + 1) code1 = '0;
      tick();
    end
    cm1 = 1'b0;
    chk("u1_done_seen", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    // Single-hart pass: 10 commits, halt with code 0 at RUN cycle 20
    start1();
    run1(20, 32'd0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 20, 10, 25);
    cm1 = 1'b1;
    repeat (5) tick();
    cm1 = 1'b0;
    chk("u1_sticky_done", 64'(d1_done), 64'd1);
    chk("u1_sticky_pass", 64'(d1_pass), 64'd1);
    chk("u1_frozen_cycle", d1_cyc, 64'd20);
    chk("u1_frozen_instret", d1_inst, 64'd10);
    chk("u1_done_dut_rst_n", 64'(d1_rstn), 64'd1);

    // Failing exit code 3, changed to 0 afterwards while ebreak stays high
    start1();
    run1(20, 32'd3, 10, 1'b0, 1'b0, 1'b1, 1'b1, 20, 10, 25);

    // Commits keep the watchdog alive past 100 total cycles
    start1();
    run1(140, 32'd0, 50, 1'b1, 1'b0, 1'b1, 1'b0, 140, 50, 145);

    // Watchdog expiry after the 100th RUN edge
    start1();
    run1(0, 32'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 100, 0, 100);

    // Final halt on the expiry cycle: halt wins
    start1();
    run1(100, 32'd0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 100, 0, 105);

    // Reset during DRAIN
    start1();
    for (int n = 1; n <= 3; n++) begin
      if (n == 3) eb1 = 1'b1;
      tick();
    end
    tick(); tick();
    chk("u1_drain_not_done", 64'(d1_done), 64'd0);
    chk("u1_drain_halt_mask", 64'(d1_hm), 64'd1);
    chk("u1_drain_cycle_frozen", d1_cyc, 64'd3);
    rst1 = 1'b0;
    tick();
    chk("u1_midrst_dut_rst_n", 64'(d1_rstn), 64'd0);
    chk("u1_midrst_halt_mask", 64'(d1_hm), 64'd0);
    chk("u1_midrst_cycle_cnt", d1_cyc, 64'd0);
    chk("u1_midrst_sim_done", 64'(d1_done), 64'd0);
    start1();
    run1(7, 32'd0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 7, 2, 12);

    // Four harts halting at RUN cycles 5, 9, 9, 30; hart 2 exits with 1
    rst4 = 1'b0; eb4 = '0; cm4 = '0; code4 = '0;
    tick(); tick();
    chk("u4_rst_halt_mask", 64'(d4_hm), 64'd0);
    chk("u4_rst_dut_rst_n", 64'(d4_rstn), 64'd0);
    rst4 = 1'b1;
    repeat (16) tick();
    chk("u4_dut_rst_n_edge16", 64'(d4_rstn), 64'd1);
    q4.push_back('{pass: 1'b0, tmo: 1'b0, hm: 4'hf, fm: 4'h4, cyc: 64'd30, inst: 64'd13, at: edge_n + 35});
    for (int n = 1; n <= 200 && q4.size() != 0; n++) begin
      cm4 = (n <= 3) ? 4'hf : ((n == 10) ? 4'h1 : 4'h0);
      if (n == 5) eb4[0] = 1'b1;
      if (n == 9) begin
        eb4[2:1] = 2'b11;
        code4[95:64] = 32'h1;
      end
      if (n == 12) code4[95:64] = 32'h0;
      if (n == 30) eb4[3] = 1'b1;
      tick();
      if (n == 5) chk("u4_halt_mask_c5", 64'(d4_hm), 64'h1);
      if (n == 9) chk("u4_halt_mask_c9", 64'(d4_hm), 64'h7);
      if (n == 9) chk("u4_fail_mask_c9", 64'(d4_fm), 64'h4);
      if (n == 29) chk("u4_halt_mask_c29", 64'(d4_hm), 64'h7);
      if (n == 29) chk("u4_cycle_cnt_c29", d4_cyc, 64'd29);
      if (n == 30) chk("u4_halt_mask_c30", 64'(d4_hm), 64'hf);
    end
    cm4 = '0;
    chk("u4_done_seen", 64'(q4.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sim_ctrl.md
# sim_ctrl

Simulation control block that sits between the simulation top and one or more CPU cores. It generates a parametrised, cycle-counted DUT reset and collects per-hart `ebreak_end` halts together with exit codes. It also runs a no-progress watchdog, keeps cycle and retired-instruction counters, and raises a single sticky `sim_done` with a pass/fail/timeout verdict. The testbench waits on `sim_done` to end the run.

## Interface
Parameters:
- `NUM_HARTS`, 1: number of monitored cores; each has its own halt, commit and exit-code channel.
- `RST_CYCLES`, 16: cycles `dut_rst_n` is held low after `rst_n` releases; must be ≥ 1.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit in cycles without progress; 0 disables the watchdog.
- `DRAIN_CYCLES`, 4: cycles between the last halt and `sim_done`; 0 is allowed.
- `CNT_W`, 64: width of the cycle and instret counters.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `ebreak_end`, in, NUM_HARTS: per-hart halt level, active-high.
- `commit`, in, NUM_HARTS: per-hart retire pulse, one instruction per asserted cycle.
- `exit_code`, in, 32×NUM_HARTS: per-hart a0 value; hart i uses bits [32i+31:32i].
- `dut_rst_n`, out, 1: reset to the cores, active-low.
- `sim_done`, out, 1: sticky end-of-simulation flag.
- `sim_pass`, out, 1: valid when `sim_done`=1. It is 1 only if all harts halted and every `fail_mask` bit is 0.
- `sim_timeout`, out, 1: valid when `sim_done`=1. It is 1 when the watchdog ended the run.
- `halt_mask`, out, NUM_HARTS: sticky per-hart "halt seen" bits.
- `fail_mask`, out, NUM_HARTS: bit i is 1 when hart i halted with a nonzero exit code.
- `cycle_cnt`, out, CNT_W: cycles spent in RUN.
- `instret_cnt`, out, CNT_W: total commits summed over all harts.

## Operation
- FSM states: RST, RUN, DRAIN, DONE.
- `rst_n`=0 at a rising edge forces the following register values, from any state:
  - state RST, `dut_rst_n`=0, `sim_done`/`sim_pass`/`sim_timeout`=0;
  - `halt_mask`/`fail_mask`=0, all counters 0, watchdog 0.
- **RST:** a reset counter increments each cycle with `rst_n`=1. When it reaches RST_CYCLES, the block registers `dut_rst_n`=1 and enters RUN. Core inputs are ignored in RST.
- **RUN:**
  - `cycle_cnt` += 1 every cycle.
  - `instret_cnt` += popcount(`commit`). Commits from harts whose `halt_mask` bit is already set still count.
  - Counters wrap modulo 2^CNT_W.
  - A new halt on hart i (`ebreak_end[i]`=1 and `halt_mask[i]`=0) sets `halt_mask[i]`. In the same edge it latches `fail_mask[i]` = (`exit_code[i]` != 0). Later exit-code changes are ignored.
  - The watchdog clears on any `commit` bit or any new halt; otherwise it increments.
  - Go to DRAIN when `halt_mask` (including halts arriving this cycle) is all ones.
  - Otherwise go to DONE with `sim_timeout`=1 when the watchdog would reach TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0).
- Simultaneous final halt and watchdog expiry: the halt wins. The block enters DRAIN and `sim_timeout` stays 0.
- **DRAIN:** counters and masks are frozen and inputs are ignored. After DRAIN_CYCLES cycles, go to DONE. With DRAIN_CYCLES=0 the block goes RUN→DONE directly.
- **DONE:**
  - `sim_done`=1.
  - `sim_pass` = ~`sim_timeout` & ~|`fail_mask`.
  - All outputs hold until `rst_n`=0.
  - `dut_rst_n` stays 1; the cores are not re-reset.
- Reset mid-RUN or mid-DRAIN: the block returns to RST on the next edge, the whole sequence restarts, and `dut_rst_n` drops on that same edge.

## Timing
- All outputs are registered and change only on rising `clk`.
- Counting edges from the first edge sampling `rst_n`=1 (edge 1), `dut_rst_n` rises after edge RST_CYCLES.
- The first RUN cycle samples core inputs at edge RST_CYCLES+1, and `cycle_cnt` reads 1 after it.
- A halt sampled at edge k is visible on `halt_mask`/`fail_mask` after edge k.
- `sim_done` rises after edge k+DRAIN_CYCLES+1, where k is the edge that completes `halt_mask`.
- Watchdog: with no progress from edge j onward, `sim_done`/`sim_timeout` rise after edge j+TIMEOUT_CYCLES−1.
- `ebreak_end` is level-sensitive and may stay high indefinitely; only the first rise per hart is acted on.

## Test plan
- **Reset and single-hart pass.** NUM_HARTS=1, RST_CYCLES=16. Release `rst_n` and pulse `commit` 10 times. Assert `ebreak_end` with `exit_code`=0 at RUN cycle 20.
  - `dut_rst_n` rises after edge 16 and `instret_cnt`=10.
  - `cycle_cnt` freezes at 20.
  - `sim_done`=1 and `sim_pass`=1 exactly DRAIN_CYCLES+1 edges after the halt.
- **Failing exit code.** Same as above with `exit_code`=3, which then changes to 0 while `ebreak_end` stays high. Required: `fail_mask`=1, `sim_pass`=0, `sim_timeout`=0.
- **Multi-hart ordering.** NUM_HARTS=4. Harts halt at RUN cycles 5, 9, 9 and 30; hart 2 has code 0x1, all others 0.
  - `halt_mask` reads 0001, then 0111, then 1111.
  - DRAIN is entered only after cycle 30.
  - `fail_mask`=0100 and `sim_pass`=0.
- **Watchdog.** TIMEOUT_CYCLES=100 with no commits and no halt. Required: `sim_done`=`sim_timeout`=1 after the 100th RUN edge, and `sim_pass`=0.
- **Watchdog tie and reset mid-run.**
  - Make the final halt arrive on the expiry cycle. Required: `sim_timeout`=0 and `sim_pass`=1.
  - Then drop `rst_n` during DRAIN. Required: all outputs return to 0 next edge, `dut_rst_n`=0, and the RST sequence repeats.
